// File: rtl/bus_pkg.sv
// Shared bus widths, sequencer state encoding and the queued command record.
// Pure declarations: no latency, no backpressure.
package bus_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        GAP  = 2'd3
    } state_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);
endpackage

// File: rtl/bus_master_seq_if.sv
// Command, bus-master and read-response signals of the queued bus initiator.
// Wiring only: no latency, no backpressure of its own.
interface bus_master_seq_if;
    import bus_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;

    logic              m_req;
    logic              m_grant;
    logic              m_wr;
    logic [ADDR_W-1:0] m_address;
    logic [DATA_W-1:0] m_dout;
    logic [DATA_W-1:0] m_din;

    logic              rsp_valid;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_data, m_grant, m_din,
        output cmd_ready, m_req, m_wr, m_address, m_dout,
               rsp_valid, rsp_addr, rsp_data, busy
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_data, m_grant, m_din,
        input  cmd_ready, m_req, m_wr, m_address, m_dout,
               rsp_valid, rsp_addr, rsp_data, busy
    );
endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; head is visible combinationally, push lands next cycle.
// Push is dropped while full and pop is ignored while empty; no bypass path.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic             last
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit tells full from empty when the index bits match.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign last     = ((wr_ptr - rd_ptr) == (AW+1)'(1));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// File: rtl/bus_master_seq.sv
// Queued bus initiator: m_req one cycle after a push, read data returned one cycle after accept.
// cmd_ready drops only when the queue is full; responses have no backpressure.
module bus_master_seq
    import bus_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    bus_master_seq_if.master    bus
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  burst_cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              req;
    logic              accept;
    logic              push_en;
    logic              full;
    logic              empty;
    logic              last;
    cmd_t              cmd_in;
    cmd_t              head;
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_addr;
    logic              rsp_valid_q;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic [DATA_W-1:0] rsp_data_q;

    assign push_en = bus.cmd_valid && !full;
    assign cmd_in  = '{wr: bus.cmd_wr, addr: bus.cmd_addr, data: bus.cmd_data};

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .rst      (reset_n),
        .push     (push_en),
        .push_dat (cmd_in),
        .pop      (accept),
        .head_dat (head),
        .full     (full),
        .empty    (empty),
        .last     (last)
    );

    // Leaving IDLE/GAP looks at an incoming push so m_req rises the cycle after it lands.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = burst_cnt;
        req       = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: if (!empty || push_en) state_nxt = REQ;
            REQ:  req = 1'b1;
            XFER: begin
                req = !empty && (burst_cnt < CNT_W'(MAX_BURST));
                if (!req) state_nxt = IDLE;
            end
            GAP: begin
                cnt_nxt   = '0;
                state_nxt = (!empty || push_en) ? REQ : IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        accept = req && bus.m_grant;
        if (accept) begin
            cnt_nxt = (state == REQ) ? CNT_W'(1) : burst_cnt + CNT_W'(1);
            if (cnt_nxt == CNT_W'(MAX_BURST))
                state_nxt = GAP;
            else if (last && !push_en)
                state_nxt = IDLE;
            else
                state_nxt = XFER;
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state       <= IDLE;
            burst_cnt   <= '0;
            rd_pend     <= 1'b0;
            rd_addr     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            state       <= state_nxt;
            burst_cnt   <= cnt_nxt;
            rd_pend     <= accept && !head.wr;
            rsp_valid_q <= rd_pend;
            if (accept) rd_addr <= head.addr;
            // The slave drives m_din the cycle after it accepted the read.
            if (rd_pend) begin
                rsp_addr_q <= rd_addr;
                rsp_data_q <= bus.m_din;
            end
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.m_req     = req;
    assign bus.m_wr      = req ? head.wr   : 1'b0;
    assign bus.m_address = req ? head.addr : '0;
    assign bus.m_dout    = req ? head.data : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = !empty || rd_pend;
endmodule

// File: tb/tb_bus_master_seq.sv
// Directed and random stimulus against a RAM slave and an in-order transaction model.
module tb_bus_master_seq;
    import bus_pkg::*;

    localparam int DEPTH     = 4;
    localparam int MAX_BURST = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_master_seq_if bif();

    bus_master_seq #(
        .DEPTH     (DEPTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk     (clk),
        .reset_n (rst),
        .bus     (bif.master)
    );

    logic [31:0] ram [256];
    logic [31:0] mdl [256];
    cmd_t        exp_acc[$];
    cmd_t        acc_q[$];
    logic [47:0] exp_rsp[$];
    logic [47:0] rsp_q[$];
    int          rd_cyc_q[$];
    int          rsp_cyc_q[$];
    bit          req_trace[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          rand_grant = 0;

    // RAM slave: write on accept, read data presented the following cycle.
    always @(posedge clk) begin
        if (bif.m_req && bif.m_grant) begin
            if (bif.m_wr) ram[bif.m_address[7:0]] = bif.m_dout;
            else          bif.m_din <= ram[bif.m_address[7:0]];
        end
    end

    // Observe bus accepts and responses just after the stimulus has settled.
    always @(negedge clk) begin
        #2;
        cyc++;
        if (!rst) begin
            req_trace.push_back(bif.m_req);
            if (bif.m_req && bif.m_grant) begin
                acc_q.push_back('{wr: bif.m_wr, addr: bif.m_address, data: bif.m_dout});
                if (!bif.m_wr) rd_cyc_q.push_back(cyc);
            end
            if (bif.rsp_valid) begin
                rsp_q.push_back({bif.rsp_addr, bif.rsp_data});
                rsp_cyc_q.push_back(cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rand_grant) bif.m_grant = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input logic wr, input logic [15:0] a, input logic [31:0] d, output bit ok);
        tick();
        bif.cmd_valid = 1'b1;
        bif.cmd_wr    = wr;
        bif.cmd_addr  = a;
        bif.cmd_data  = d;
        ok = bif.cmd_ready;
        if (ok) begin
            exp_acc.push_back('{wr: wr, addr: a, data: d});
            if (wr) mdl[a[7:0]] = d;
            else    exp_rsp.push_back({a, mdl[a[7:0]]});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            bif.cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag);
        bit to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            idle(1);
            if (!bif.busy && !bif.m_req) begin
                to = 1'b0;
                break;
            end
        end
        chk({tag, "_timeout"}, to, 1'b0);
        idle(3);
    endtask

    task automatic check_xfers(input string tag);
        int n;
        chk({tag, "_n_acc"}, acc_q.size(), exp_acc.size());
        n = (acc_q.size() < exp_acc.size()) ? acc_q.size() : exp_acc.size();
        for (int i = 0; i < n; i++)
            chk({tag, "_acc"},
                {acc_q[i].wr, acc_q[i].addr, acc_q[i].wr ? acc_q[i].data : 32'h0},
                {exp_acc[i].wr, exp_acc[i].addr, exp_acc[i].wr ? exp_acc[i].data : 32'h0});
        chk({tag, "_n_rsp"}, rsp_q.size(), exp_rsp.size());
        n = (rsp_q.size() < exp_rsp.size()) ? rsp_q.size() : exp_rsp.size();
        for (int i = 0; i < n; i++)
            chk({tag, "_rsp"}, rsp_q[i], exp_rsp[i]);
        n = (rsp_cyc_q.size() < rd_cyc_q.size()) ? rsp_cyc_q.size() : rd_cyc_q.size();
        for (int i = 0; i < n; i++)
            chk({tag, "_rsp_lat"}, rsp_cyc_q[i] - rd_cyc_q[i], 2);
        acc_q.delete(); exp_acc.delete(); rsp_q.delete(); exp_rsp.delete();
        rd_cyc_q.delete(); rsp_cyc_q.delete();
    endtask

    initial begin
        bit   ok;
        int   idx;
        int   run1;
        int   gap;
        int   run2;
        cmd_t first;

        bif.cmd_valid = 1'b0;
        bif.cmd_wr    = 1'b0;
        bif.cmd_addr  = '0;
        bif.cmd_data  = '0;
        bif.m_grant   = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
            mdl[i] = ram[i];
        end
        ram[8'h20] = 32'hCAFE_F00D;
        mdl[8'h20] = 32'hCAFE_F00D;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_m_req", bif.m_req, 1'b0);
        chk("rst_m_wr", bif.m_wr, 1'b0);
        chk("rst_m_address", bif.m_address, 16'h0);
        chk("rst_m_dout", bif.m_dout, 32'h0);
        chk("rst_cmd_ready", bif.cmd_ready, 1'b1);
        chk("rst_busy", bif.busy, 1'b0);
        chk("rst_rsp", {bif.rsp_valid, bif.rsp_addr, bif.rsp_data}, 49'h0);
        rst = 1'b0;

        // Single write with grant tied high
        bif.m_grant = 1'b1;
        idle(2);
        push(1'b1, 16'h0010, 32'hDEAD_BEEF, ok);
        idle(1);
        chk("wr_m_req", bif.m_req, 1'b1);
        chk("wr_m_bus", {bif.m_wr, bif.m_address, bif.m_dout}, {1'b1, 16'h0010, 32'hDEAD_BEEF});
        idle(1);
        chk("wr_m_req_drop", bif.m_req, 1'b0);
        chk("wr_busy_clear", bif.busy, 1'b0);
        idle(2);
        check_xfers("wr");

        // Read return
        push(1'b0, 16'h0020, 32'h0, ok);
        wait_done("rd");
        check_xfers("rd");

        // Grant stall in the middle of a burst
        bif.m_grant = 1'b0;
        push(1'b1, 16'h0001, 32'hA1A1_A1A1, ok);
        push(1'b0, 16'h0002, 32'h0, ok);
        push(1'b1, 16'h0003, 32'hA3A3_A3A3, ok);
        idle(1);
        chk("stall_req_wait", {bif.m_req, bif.m_address}, {1'b1, 16'h0001});
        bif.m_grant = 1'b1;
        idle(1);
        bif.m_grant = 1'b0;
        chk("stall_hold", {bif.m_req, bif.m_address}, {1'b1, 16'h0002});
        repeat (2) begin
            idle(1);
            chk("stall_hold", {bif.m_req, bif.m_address}, {1'b1, 16'h0002});
        end
        bif.m_grant = 1'b1;
        wait_done("stall");
        check_xfers("stall");

        // Burst limit: 10 writes streamed in with grant held
        req_trace.delete();
        for (int i = 0; i < 10; i++)
            push(1'b1, 16'h0040 + 16'(i), $urandom, ok);
        wait_done("burst");
        idx = 0;
        while (idx < req_trace.size() && !req_trace[idx]) idx++;
        run1 = 0; gap = 0; run2 = 0;
        while (idx < req_trace.size() && req_trace[idx])  begin run1++; idx++; end
        while (idx < req_trace.size() && !req_trace[idx] && gap < 4) begin gap++; idx++; end
        while (idx < req_trace.size() && req_trace[idx])  begin run2++; idx++; end
        chk("burst_first_run", run1, MAX_BURST);
        chk("burst_gap", gap, 1);
        chk("burst_second_run", run2, 2);
        check_xfers("burst");

        // Full FIFO with grant held low
        bif.m_grant = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            push(1'b1, 16'h0050 + 16'(i), $urandom, ok);
            chk("full_push_ok", ok, 1'b1);
        end
        push(1'b1, 16'h0060, 32'h6666_6666, ok);
        chk("full_cmd_ready", bif.cmd_ready, 1'b0);
        push(1'b1, 16'h0060, 32'h6666_6666, ok);
        chk("full_push_refused", ok, 1'b0);
        idle(1);
        bif.m_grant = 1'b1;
        wait_done("full");
        check_xfers("full");

        // Reset between a read accept and its response
        bif.m_grant = 1'b0;
        push(1'b0, 16'h0020, 32'h0, ok);
        push(1'b1, 16'h0090, 32'h9090_9090, ok);
        push(1'b1, 16'h0091, 32'h9191_9191, ok);
        idle(1);
        bif.m_grant = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_outputs", {bif.m_req, bif.cmd_ready, bif.busy, bif.rsp_valid},
            {1'b0, 1'b1, 1'b0, 1'b0});
        first = exp_acc[0];
        exp_acc.delete();
        exp_acc.push_back(first);
        exp_rsp.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            idle(1);
            chk("post_rst_idle", {bif.m_req, bif.cmd_ready, bif.busy}, {1'b0, 1'b1, 1'b0});
        end
        check_xfers("mid_rst");

        // Random commands with a randomly toggling grant
        rand_grant = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else push(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), $urandom, ok);
        end
        rand_grant  = 1'b0;
        bif.m_grant = 1'b1;
        wait_done("rnd");
        check_xfers("rnd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_master_seq.md
Name: bus_master_seq

Overview:
Queued bus initiator that plugs into a master port of BUS (req/grant, wr, 16-bit address, 32-bit write data, 32-bit read data). It accepts read and write commands from local logic into a FIFO. It arbitrates for the bus, issues the queued transfers back-to-back while granted, and returns read data on a response port. It is the initiating end of the same master/slave protocol that ram, ALU_Top and DMAC_Top answer as slaves.

Parameters:
DEPTH, 4, command FIFO entries (power of two, at least 2).
MAX_BURST, 8, maximum transfers per grant before m_req is dropped for one cycle (fairness).

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous, active-high reset (asserted = 1); the port keeps the codebase name despite the suffix.
cmd_valid  input  1  command offered.
cmd_ready  output  1  FIFO not full.
cmd_wr  input  1  1 = write, 0 = read.
cmd_addr  input  16  bus address.
cmd_data  input  32  write data (ignored for reads).
m_req  output  1  bus request.
m_grant  input  1  bus grant.
m_wr  output  1  transfer direction.
m_address  output  16  transfer address.
m_dout  output  32  write data.
m_din  input  32  read data from BUS.
rsp_valid  output  1  one-cycle pulse: read data valid.
rsp_addr  output  16  address of the returned read.
rsp_data  output  32  returned read data.
busy  output  1  FIFO non-empty or a read is outstanding.

Behaviour:
- Reset state, applied immediately and asynchronously: m_req=0, m_wr=0, m_address=0, m_dout=0, rsp_valid=0, rsp_addr=0, rsp_data=0, busy=0, FIFO empty, cmd_ready=1, FSM in IDLE, burst count 0, read-pending flag 0.
- Command push: occurs when cmd_valid and cmd_ready at a rising edge. cmd_ready = !full, with no combinational dependence on pop. When full, a same-cycle pop does not admit a push.
- Bus rule: a transfer is accepted at a rising edge where m_req=1 and m_grant=1. m_wr, m_address and m_dout reflect the FIFO head whenever m_req=1; they are 0 otherwise.
- Read data: for a read accepted at edge N, m_din is sampled at edge N+1. At that edge rsp_data and rsp_addr are loaded and rsp_valid=1 for exactly one cycle. There is no response backpressure.
- FSM states:
  - IDLE: m_req=0. Moves to REQ when the FIFO is non-empty.
  - REQ: m_req=1, head presented. On accept, pop the head, set burst count to 1, go to XFER.
  - XFER: m_req=1 while the FIFO is non-empty and burst count < MAX_BURST. Each accept pops the head and increments the count.
    - FIFO empty after a pop: go to IDLE (m_req=0 next cycle).
    - Count reaches MAX_BURST: go to GAP.
    - Grant removed (m_req=1, m_grant=0): no pop, the head is held, state stays XFER and the request continues. The count does not increment.
  - GAP: m_req=0 for exactly one cycle, count cleared. Go to REQ if the FIFO is non-empty, otherwise IDLE.
- Ordering: transfers issue strictly in command order. Read responses return in issue order, one per accepted read.
- Commands pushed during XFER extend the current burst, subject to MAX_BURST.
- Push into an empty FIFO in IDLE: m_req rises on the next cycle (one cycle of latency).
- busy = FIFO non-empty OR read-pending flag. After the last read is accepted, busy remains 1 until rsp_valid pulses.
- Reset mid-burst: FIFO contents are discarded and the outstanding read's response is suppressed (rsp_valid stays 0).
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. Full = MSBs differ and LSBs are equal.

Decomposition:
- Shared package bus_pkg: ADDR_W=16, DATA_W=32, FSM state encoding (IDLE, REQ, XFER, GAP), command record layout {wr, addr, data} = 49 bits.
- One sub-module, sync_fifo: parameterised width/depth, push/pop, full/empty, head output. It is reusable by DMAC_Top.

Test Plan:
- Reset then write: push write 0x0010 <= 0xDEADBEEF with grant tied 1. Required: m_req rises the next cycle, one accept with m_wr=1, m_address=0x0010, m_dout=0xDEADBEEF. m_req=0 the following cycle and busy returns to 0.
- Read return: ram preloaded 0xCAFEF00D at 0x0020; push read 0x0020. Required: rsp_valid pulses one cycle after the accept with rsp_addr=0x0020 and rsp_data=0xCAFEF00D.
- Grant stall: push write 0x1/read 0x2/write 0x3, grant low for 3 cycles mid-burst. Required: m_address holds during the stall, no duplicates or drops, order 0x1, 0x2, 0x3.
- Burst limit: MAX_BURST=8 with 10 writes queued. Required: exactly 8 accepts, m_req=0 for one cycle, then 2 accepts.
- Full FIFO: DEPTH=4, grant held low, push 5 commands. Required: cmd_ready=0 after the 4th push and the 5th is not accepted. After grant returns, exactly 4 transfers issue.
- Reset mid-operation: assert reset_n between a read accept and its response. Required: m_req drops immediately, no rsp_valid, FIFO empty, cmd_ready=1.
